// File: rtl/zii_slave_decode.sv
// -----------------------------------------------------------------------------
// zii_slave_decode
//
// Zorro II slave-side address decoder and bus-cycle sequencer.
//
// This block sits directly after AutoConfig and uses the bases that stage
// assigned. It recognises CPU cycles aimed at the Fast RAM window or at the
// 64 KB SDIO register window. For a hit, it drives the SRAM strobes or the
// SDIO chip select, enables the data buffers, and returns DTACK_n after a
// programmable number of C7M wait states.
//
// Parameters
//   RAM_WAIT  extra C7M edges between strobe assertion and DTACK_n for RAM (0..3)
//   IO_WAIT   extra C7M edges before DTACK_n for SDIO hits (0..7)
//
// Ports
//   C7M               in   7 MHz bus clock, rising-edge active
//   RESET_n           in   asynchronous active-low reset
//   AS_CPU_n          in   address strobe (active low)
//   UDS_n / LDS_n     in   upper / lower data strobes (active low)
//   RW_n              in   1 = read, 0 = write
//   A_HIGH[7:0]       in   address A23..A16
//   BASE_RAM[2:0]     in   RAM base A23..A21 (2 MB granules)
//   BASE_SDIO[7:0]    in   SDIO base A23..A16
//   RAM_CONFIGURED_n  in   low once BASE_RAM is valid
//   SDIO_CONFIGURED_n in   low once BASE_SDIO is valid
//   JP4               in   1 = 8 MB RAM (4 granules), 0 = 4 MB (2 granules)
//   RAM_CE_n          out  SRAM chip enable
//   RAM_OE_n          out  SRAM output enable
//   RAM_WE_n[1:0]     out  SRAM byte write enables, [1] upper, [0] lower
//   SDIO_CS_n         out  SDIO register-block select
//   DBUF_OE_n         out  data-buffer enable
//   DBUF_DIR          out  buffer direction, 1 = card drives the bus
//   DTACK_n           out  data transfer acknowledge
// -----------------------------------------------------------------------------
module zii_slave_decode #(
   parameter int unsigned RAM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 2
) (
   input  logic       C7M,
   input  logic       RESET_n,
   input  logic       AS_CPU_n,
   input  logic       UDS_n,
   input  logic       LDS_n,
   input  logic       RW_n,
   input  logic [7:0] A_HIGH,
   input  logic [2:0] BASE_RAM,
   input  logic [7:0] BASE_SDIO,
   input  logic       RAM_CONFIGURED_n,
   input  logic       SDIO_CONFIGURED_n,
   input  logic       JP4,
   output logic       RAM_CE_n,
   output logic       RAM_OE_n,
   output logic [1:0] RAM_WE_n,
   output logic       SDIO_CS_n,
   output logic       DBUF_OE_n,
   output logic       DBUF_DIR,
   output logic       DTACK_n
);

   localparam logic [2:0] RAM_WAIT_L = 3'(RAM_WAIT);
   localparam logic [2:0] IO_WAIT_L  = 3'(IO_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RAM_ACC = 2'd1,
      ST_IO_ACC  = 2'd2,
      ST_ACK     = 2'd3
   } state_t;

   state_t     state_q,   state_d;
   logic [2:0] wait_q,    wait_d;
   logic       is_ram_q,  is_ram_d;    // hit type of the running cycle
   logic       as_high_q, as_high_d;   // AS_CPU_n was high on the previous edge
   logic       ram_sel_q, ram_sel_d;
   logic       io_sel_q,  io_sel_d;
   logic       active_q,  active_d;
   logic       dtack_q,   dtack_d;

   logic [2:0] ram_off_s;
   logic [2:0] ram_size_s;
   logic       ram_hit_s;
   logic       io_hit_s;
   logic       as_s;

   // Window decode. The RAM offset wraps modulo 8 granules, so a base near the
   // top of the 16 MB map still covers the granules that wrap around to 0.
   always_comb begin
      ram_off_s  = A_HIGH[7:5] - BASE_RAM;
      ram_size_s = JP4 ? 3'd4 : 3'd2;
      ram_hit_s  = !RAM_CONFIGURED_n && (ram_off_s < ram_size_s);
      io_hit_s   = !SDIO_CONFIGURED_n && (A_HIGH == BASE_SDIO);
   end

   // State register and registered output flags.
   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q   <= ST_IDLE;
         wait_q    <= 3'd0;
         is_ram_q  <= 1'b0;
         as_high_q <= 1'b1;
         ram_sel_q <= 1'b0;
         io_sel_q  <= 1'b0;
         active_q  <= 1'b0;
         dtack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         is_ram_q  <= is_ram_d;
         as_high_q <= as_high_d;
         ram_sel_q <= ram_sel_d;
         io_sel_q  <= io_sel_d;
         active_q  <= active_d;
         dtack_q   <= dtack_d;
      end
   end

   // Next-state logic. A cycle is decoded only on the first edge that sees AS
   // low after it was high. A miss therefore stays a miss for the whole cycle,
   // and back-to-back cycles need an AS-high edge in IDLE.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      is_ram_d  = is_ram_q;
      as_high_d = AS_CPU_n;
      case (state_q)
         ST_IDLE: begin
            if (!AS_CPU_n && as_high_q) begin
               if (ram_hit_s) begin
                  state_d  = ST_RAM_ACC;
                  wait_d   = RAM_WAIT_L;
                  is_ram_d = 1'b1;
               end else if (io_hit_s) begin
                  state_d  = ST_IO_ACC;
                  wait_d   = IO_WAIT_L;
                  is_ram_d = 1'b0;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RAM_ACC, ST_IO_ACC: begin
            if (AS_CPU_n) begin
               state_d = ST_IDLE;
            end else if (wait_q == 3'd0) begin
               state_d = ST_ACK;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         ST_ACK: begin
            if (AS_CPU_n) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output flags, derived from the next state so that they switch on the
   // same edge as the state they describe.
   always_comb begin
      ram_sel_d = (state_d == ST_RAM_ACC) || ((state_d == ST_ACK) && is_ram_d);
      io_sel_d  = (state_d == ST_IO_ACC)  || ((state_d == ST_ACK) && !is_ram_d);
      active_d  = (state_d != ST_IDLE);
      dtack_d   = (state_d == ST_ACK);
   end

   // Every bus-facing output is qualified with AS directly. This lets the
   // strobes, the buffer enable and DTACK_n release as soon as the master
   // negates AS, without waiting for the next C7M edge.
   always_comb begin
      as_s        = !AS_CPU_n;
      RAM_CE_n    = !(ram_sel_q && as_s);
      RAM_OE_n    = !(ram_sel_q && as_s && RW_n);
      RAM_WE_n[1] = !(ram_sel_q && as_s && !RW_n && !UDS_n);
      RAM_WE_n[0] = !(ram_sel_q && as_s && !RW_n && !LDS_n);
      SDIO_CS_n   = !(io_sel_q && as_s);
      DBUF_OE_n   = !(active_q && as_s);
      DBUF_DIR    = active_q && as_s && RW_n;
      DTACK_n     = !(dtack_q && as_s);
   end

endmodule

// File: tb/tb_zii_slave_decode.sv
module tb_zii_slave_decode;

   logic       C7M = 1'b0;
   logic       RESET_n;
   logic       AS_CPU_n, UDS_n, LDS_n, RW_n;
   logic [7:0] A_HIGH;
   logic [2:0] BASE_RAM;
   logic [7:0] BASE_SDIO;
   logic       RAM_CONFIGURED_n, SDIO_CONFIGURED_n, JP4;
   logic       RAM_CE_n, RAM_OE_n, SDIO_CS_n, DBUF_OE_n, DBUF_DIR, DTACK_n;
   logic [1:0] RAM_WE_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Output bundle order: {CE, OE, WE[1], WE[0], CS, DBUF_OE, DIR, DTACK}
   localparam logic [7:0] O_IDLE    = 8'b1111_1101;
   localparam logic [7:0] O_RAM_RD  = 8'b0011_1011;
   localparam logic [7:0] O_RAM_RDA = 8'b0011_1010;
   localparam logic [7:0] O_RAM_WR  = 8'b0101_1001;
   localparam logic [7:0] O_RAM_WRA = 8'b0101_1000;
   localparam logic [7:0] O_IO_RD   = 8'b1111_0011;
   localparam logic [7:0] O_IO_RDA  = 8'b1111_0010;

   zii_slave_decode #(.RAM_WAIT(0), .IO_WAIT(2)) dut (
      .C7M(C7M), .RESET_n(RESET_n), .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n),
      .LDS_n(LDS_n), .RW_n(RW_n), .A_HIGH(A_HIGH), .BASE_RAM(BASE_RAM),
      .BASE_SDIO(BASE_SDIO), .RAM_CONFIGURED_n(RAM_CONFIGURED_n),
      .SDIO_CONFIGURED_n(SDIO_CONFIGURED_n), .JP4(JP4),
      .RAM_CE_n(RAM_CE_n), .RAM_OE_n(RAM_OE_n), .RAM_WE_n(RAM_WE_n),
      .SDIO_CS_n(SDIO_CS_n), .DBUF_OE_n(DBUF_OE_n), .DBUF_DIR(DBUF_DIR),
      .DTACK_n(DTACK_n)
   );

   always #5 C7M = ~C7M;

   function automatic logic [7:0] outs();
      return {RAM_CE_n, RAM_OE_n, RAM_WE_n, SDIO_CS_n, DBUF_OE_n, DBUF_DIR, DTACK_n};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge C7M);
      #1;
   endtask

   // One bus cycle: AS low, count edges until DTACK_n (bounded), then release AS.
   task automatic do_cycle(input string tag, input logic [7:0] a, input logic rw,
                           input logic uds, input logic lds,
                           input logic [7:0] exp_first, input logic [7:0] exp_ack,
                           input int exp_edges);
      int n;
      A_HIGH = a; RW_n = rw; UDS_n = uds; LDS_n = lds;
      AS_CPU_n = 1'b0;
      n = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 1) check({tag, "_first"}, outs(), exp_first);
         if (DTACK_n == 1'b0) begin
            n = i;
            break;
         end
      end
      check({tag, "_lat"}, 8'(n), 8'(exp_edges));
      if (exp_edges > 0) check({tag, "_ack"}, outs(), exp_ack);
      AS_CPU_n = 1'b1;
      #1;
      check({tag, "_release"}, outs(), O_IDLE);
      tick();
      tick();
      UDS_n = 1'b1; LDS_n = 1'b1; RW_n = 1'b1;
   endtask

   initial begin
      RESET_n = 1'b0; AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW_n = 1'b1;
      A_HIGH = 8'h00; BASE_RAM = 3'b000; BASE_SDIO = 8'h00;
      RAM_CONFIGURED_n = 1'b1; SDIO_CONFIGURED_n = 1'b1; JP4 = 1'b1;
      tick();
      tick();
      check("reset", outs(), O_IDLE);
      RESET_n = 1'b1;
      tick();

      // RAM window, 8 MB
      BASE_RAM = 3'b001; RAM_CONFIGURED_n = 1'b0; JP4 = 1'b1;
      do_cycle("ram_rd_7f", 8'h7F, 1'b1, 1'b0, 1'b0, O_RAM_RD, O_RAM_RDA, 2);
      do_cycle("ram_miss_a0", 8'hA0, 1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 0);

      // 4 MB window and wrap-around
      JP4 = 1'b0;
      do_cycle("ram4_5f", 8'h5F, 1'b1, 1'b0, 1'b0, O_RAM_RD, O_RAM_RDA, 2);
      do_cycle("ram4_miss_60", 8'h60, 1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 0);
      BASE_RAM = 3'b111;
      do_cycle("ram_wrap_00", 8'h00, 1'b1, 1'b0, 1'b0, O_RAM_RD, O_RAM_RDA, 2);
      BASE_RAM = 3'b001; JP4 = 1'b1;

      // Upper-byte write
      do_cycle("ram_wr_upper", 8'h40, 1'b0, 1'b0, 1'b1, O_RAM_WR, O_RAM_WRA, 2);

      // SDIO window
      SDIO_CONFIGURED_n = 1'b0; BASE_SDIO = 8'hE9;
      do_cycle("io_rd_e9", 8'hE9, 1'b1, 1'b0, 1'b0, O_IO_RD, O_IO_RDA, 4);
      SDIO_CONFIGURED_n = 1'b1;
      do_cycle("io_unconf", 8'hE9, 1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 0);
      SDIO_CONFIGURED_n = 1'b0;

      // Abort during the IO wait states
      A_HIGH = 8'hE9; RW_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0;
      AS_CPU_n = 1'b0;
      tick();
      tick();
      check("io_abort_wait", outs(), O_IO_RD);
      AS_CPU_n = 1'b1;
      #1;
      check("io_abort_rel", outs(), O_IDLE);
      tick();
      tick();
      do_cycle("io_after_abort", 8'hE9, 1'b1, 1'b0, 1'b0, O_IO_RD, O_IO_RDA, 4);

      // Reset pulsed mid RAM cycle
      A_HIGH = 8'h7F; RW_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0;
      AS_CPU_n = 1'b0;
      tick();
      check("rst_mid_before", outs(), O_RAM_RD);
      RESET_n = 1'b0;
      #1;
      check("rst_mid_outs", outs(), O_IDLE);
      tick();
      check("rst_mid_no_dtack", outs(), O_IDLE);
      AS_CPU_n = 1'b1;
      RESET_n = 1'b1;
      tick();
      do_cycle("ram_after_rst", 8'h7F, 1'b1, 1'b0, 1'b0, O_RAM_RD, O_RAM_RDA, 2);

      // Overlap: both windows hit, RAM wins
      BASE_SDIO = 8'h20;
      do_cycle("overlap_20", 8'h20, 1'b1, 1'b0, 1'b0, O_RAM_RD, O_RAM_RDA, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/zii_slave_decode.md
Name: zii_slave_decode

Overview:
- Zorro II slave-side address decoder and bus-cycle sequencer, directly downstream of the AutoConfig stage.
- Consumes the assigned bases (BASE_RAM, BASE_SDIO) and the configured flags.
- Decodes CPU cycles that hit Fast RAM or the SDIO I/O window and drives the SRAM strobes, the SDIO chip select, the data-buffer controls and DTACK_n with programmable wait states.

Parameters:
- RAM_WAIT, default 0: extra C7M cycles between strobe assertion and DTACK_n for RAM hits (0..3).
- IO_WAIT, default 2: extra C7M cycles before DTACK_n for SDIO hits (0..7).

Ports:
- C7M  input  1  7 MHz Zorro II bus clock; all state changes on rising edge.
- RESET_n  input  1  asynchronous, active-low reset.
- AS_CPU_n  input  1  address strobe, active low.
- UDS_n  input  1  upper data strobe, active low.
- LDS_n  input  1  lower data strobe, active low.
- RW_n  input  1  1 = read, 0 = write.
- A_HIGH  input  8  address bits A23..A16.
- BASE_RAM  input  3  RAM base, A23..A21 (2 MB granules).
- BASE_SDIO  input  8  SDIO base, A23..A16 (64 KB window).
- RAM_CONFIGURED_n  input  1  low once RAM base is valid.
- SDIO_CONFIGURED_n  input  1  low once SDIO base is valid.
- JP4  input  1  1 = 8 MB RAM, 0 = 4 MB RAM.
- RAM_CE_n  output  1  SRAM chip enable.
- RAM_OE_n  output  1  SRAM output enable.
- RAM_WE_n  output  2  SRAM byte write enables: [1] = upper, [0] = lower.
- SDIO_CS_n  output  1  SDIO register-block select.
- DBUF_OE_n  output  1  data-buffer enable.
- DBUF_DIR  output  1  buffer direction: 1 = card drives bus (read).
- DTACK_n  output  1  data transfer acknowledge to the bus.

Behaviour:
- Reset: FSM to IDLE, asynchronously. Reset mid-cycle drops every strobe immediately, with no DTACK.
- Reset values: RAM_CE_n = 1, RAM_OE_n = 1, RAM_WE_n = 2'b11, SDIO_CS_n = 1, DBUF_OE_n = 1, DBUF_DIR = 0, DTACK_n = 1.
- RAM hit: !RAM_CONFIGURED_n and off < size, where off = (A_HIGH[7:5] - BASE_RAM) mod 8 (3-bit wrap arithmetic). Size is 4 granules when JP4 = 1, 2 granules when JP4 = 0.
- SDIO hit: !SDIO_CONFIGURED_n and A_HIGH == BASE_SDIO.
- Unconfigured windows never decode, so the E8xxxx AutoConfig space is never claimed by this block.
- Both hits true at once: RAM wins.
- Hit type is latched on the first C7M edge with AS_CPU_n low in IDLE. Base or configured-flag changes mid-cycle do not affect the running cycle.
- FSM states:
  - IDLE -> RAM_ACC on a RAM hit; IDLE -> IO_ACC on an SDIO hit; otherwise stay in IDLE.
  - RAM_ACC: load wait counter with RAM_WAIT; decrement each edge; at 0 -> ACK.
  - IO_ACC: load wait counter with IO_WAIT; same countdown -> ACK.
  - ACK: DTACK_n = 0; stay until AS_CPU_n is sampled high -> IDLE.
  - Any state other than IDLE with AS_CPU_n sampled high -> IDLE (abort, no DTACK).
- Strobes while in RAM_ACC or ACK-from-RAM, each gated combinationally with !AS_CPU_n so they release the instant AS negates:
  - RAM_CE_n = 0.
  - RAM_OE_n = !RW_n.
  - RAM_WE_n[1] = RW_n | UDS_n.
  - RAM_WE_n[0] = RW_n | LDS_n.
- SDIO strobes: SDIO_CS_n = 0 in IO_ACC or ACK-from-IO, same !AS_CPU_n gating.
- Buffers: DBUF_OE_n = 0 whenever any cycle is active. DBUF_DIR = RW_n during an active cycle, 0 otherwise.
- DTACK_n: registered, asserted only in ACK, gated with !AS_CPU_n.
- Latency from the first edge sampling AS low with a hit to DTACK_n low: RAM = RAM_WAIT + 2 edges; IO = IO_WAIT + 2 edges.
- Back-to-back cycles: a new cycle cannot start until IDLE has been re-entered (at least one edge with AS high).

Test Plan:
- After reset, BASE_RAM = 3'b001, RAM_CONFIGURED_n = 0, JP4 = 1, read at A_HIGH = 8'h7F -> RAM_CE_n = 0, RAM_OE_n = 0, DBUF_DIR = 1, DTACK_n low on edge 2; A_HIGH = 8'hA0 -> no response, DTACK_n stays 1.
- JP4 = 0, same base: A_HIGH = 8'h5F hits; A_HIGH = 8'h60 misses. BASE_RAM = 3'b111, A_HIGH = 8'h00 -> hit via wrap (off = 1).
- Write at a RAM address with UDS_n = 0, LDS_n = 1 -> RAM_WE_n = 2'b01, RAM_OE_n = 1; AS_CPU_n high -> all strobes high in the same delta, FSM in IDLE on the next edge.
- SDIO_CONFIGURED_n = 0, BASE_SDIO = 8'hE9, read at A_HIGH = 8'hE9 with IO_WAIT = 2 -> SDIO_CS_n low, DTACK_n low on edge 4. With SDIO_CONFIGURED_n = 1 -> no response.
- AS_CPU_n negated during the IO wait, or RESET_n pulsed mid-RAM cycle -> no DTACK, all outputs at reset values, next cycle decodes normally.
- Overlapping configuration (both hits true) -> RAM strobes only, SDIO_CS_n stays 1.
